// File: rtl/seq_lut_mult.sv
// Sequential digit-serial multiplier: one DIGIT x DIGIT product per cycle from a constant ROM,
// accumulated with shifts; valid/ready on both sides, per-op signed/unsigned mode.
module seq_lut_mult #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [WIDTH-1:0]     io_in_lhs,
    input  logic [WIDTH-1:0]     io_in_rhs,
    input  logic                 io_in_signed,
    output logic                 io_out_valid,
    input  logic                 io_out_ready,
    output logic [2*WIDTH-1:0]   io_out_data
);

    localparam int unsigned N         = WIDTH / DIGIT;
    localparam int unsigned CW        = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW        = 2 * WIDTH;
    localparam int unsigned DW        = 2 * DIGIT;
    localparam int unsigned ROM_DEPTH = 1 << DW;
    localparam logic [CW-1:0] LAST    = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  lhs_mag_q, rhs_mag_q;
    logic              neg_q;
    logic [PW-1:0]     acc_q;
    logic [CW-1:0]     i_q, j_q;
    logic [PW-1:0]     data_q;

    logic [DIGIT-1:0]  a_dig, b_dig;
    logic [DW-1:0]     pp;
    logic [PW-1:0]     acc_sum;
    logic [PW-1:0]     result;
    logic              last;
    logic [WIDTH-1:0]  lhs_mag_d, rhs_mag_d;

    // Product ROM indexed by {a, b}; contents are elaboration-time constants
    logic [DW-1:0] rom [ROM_DEPTH];
    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam int unsigned A = k / (1 << DIGIT);
        localparam int unsigned B = k % (1 << DIGIT);
        assign rom[k] = DW'(A * B);
    end

    // Operand magnitudes at accept; -2^(W-1) maps onto itself as an unsigned magnitude
    always_comb begin
        lhs_mag_d = (io_in_signed && io_in_lhs[WIDTH-1]) ? WIDTH'(-io_in_lhs) : io_in_lhs;
        rhs_mag_d = (io_in_signed && io_in_rhs[WIDTH-1]) ? WIDTH'(-io_in_rhs) : io_in_rhs;
    end

    // Current digit pair, shifted partial product and final sign fix-up
    always_comb begin
        a_dig   = DIGIT'(lhs_mag_q >> (DIGIT * 32'(i_q)));
        b_dig   = DIGIT'(rhs_mag_q >> (DIGIT * 32'(j_q)));
        pp      = rom[{a_dig, b_dig}];
        acc_sum = acc_q + (PW'(pp) << (DIGIT * (32'(i_q) + 32'(j_q))));
        result  = neg_q ? PW'(-acc_sum) : acc_sum;
        last    = (i_q == LAST) && (j_q == LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (io_in_valid)  state_d = CALC;
            CALC:    if (last)         state_d = DONE;
            DONE:    if (io_out_ready) state_d = IDLE;
            default:                   state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lhs_mag_q <= '0;
            rhs_mag_q <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            data_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (io_in_valid) begin
                        lhs_mag_q <= lhs_mag_d;
                        rhs_mag_q <= rhs_mag_d;
                        neg_q     <= io_in_signed & (io_in_lhs[WIDTH-1] ^ io_in_rhs[WIDTH-1]);
                        acc_q     <= '0;
                        i_q       <= '0;
                        j_q       <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_sum;
                    if (j_q == LAST) begin
                        j_q <= '0;
                        i_q <= i_q + CW'(1);
                    end else begin
                        j_q <= j_q + CW'(1);
                    end
                    if (last) data_q <= result;
                end
                default: ;
            endcase
        end
    end

    assign io_in_ready  = (state_q == IDLE);
    assign io_out_valid = (state_q == DONE);
    assign io_out_data  = data_q;

endmodule

// File: tb/tb_seq_lut_mult.sv
// Scoreboard bench for seq_lut_mult: 8-bit and 16-bit instances, latency, backpressure, reset abort.
module tb_seq_lut_mult;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, in_signed, out_valid, out_ready;
    logic [7:0]  lhs, rhs;
    logic [15:0] out_data;

    logic        w_in_valid, w_in_ready, w_in_signed, w_out_valid, w_out_ready;
    logic [15:0] w_lhs, w_rhs;
    logic [31:0] w_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] q8[$];
    logic [31:0] q16[$];

    seq_lut_mult #(.WIDTH(8), .DIGIT(4)) dut8 (
        .clk(clk), .reset(rst_n),
        .io_in_valid(in_valid), .io_in_ready(in_ready),
        .io_in_lhs(lhs), .io_in_rhs(rhs), .io_in_signed(in_signed),
        .io_out_valid(out_valid), .io_out_ready(out_ready), .io_out_data(out_data)
    );

    seq_lut_mult #(.WIDTH(16), .DIGIT(4)) dut16 (
        .clk(clk), .reset(rst_n),
        .io_in_valid(w_in_valid), .io_in_ready(w_in_ready),
        .io_in_lhs(w_lhs), .io_in_rhs(w_rhs), .io_in_signed(w_in_signed),
        .io_out_valid(w_out_valid), .io_out_ready(w_out_ready), .io_out_data(w_out_data)
    );

    // Reference product of two w-bit operands, truncated to 2*w bits
    function automatic longint unsigned gold(input longint unsigned a, input longint unsigned b,
                                             input int w, input bit sgn);
        longint sa, sb, p;
        sa = longint'(a);
        sb = longint'(b);
        if (sgn && a[w-1]) sa = sa - (longint'(1) << w);
        if (sgn && b[w-1]) sb = sb - (longint'(1) << w);
        p = sa * sb;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic pop_check8(input string name);
        logic [15:0] want;
        n_checks++;
        if (q8.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected result got %h, scoreboard empty", name, out_data);
        end else begin
            want = q8.pop_front();
            if (out_data !== want) begin
                n_fail++;
                $display("FAIL %s data got %h want %h", name, out_data, want);
            end
        end
    endtask

    // One 8-bit transaction with latency and handshake checks (out_ready assumed 1)
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit s,
                       input logic [15:0] expv, input string name);
        int k;
        k = 0;
        while (!in_ready && k < 50) begin step(); k++; end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s in_ready got %b want 1", name, in_ready);
        end
        lhs = a; rhs = b; in_signed = s; in_valid = 1'b1;
        q8.push_back(expv);
        step();
        in_valid = 1'b0;
        lhs = 8'($urandom); rhs = 8'($urandom); in_signed = 1'($urandom);
        k = 0;
        while (!out_valid && k < 50) begin step(); k++; end
        n_checks++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL %s latency got %0d want 4", name, k);
        end
        pop_check8(name);
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s post-handshake valid/ready got %b/%b want 0/1", name, out_valid, in_ready);
        end
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input bit s,
                        input logic [31:0] expv, input string name);
        int k;
        logic [31:0] want;
        k = 0;
        while (!w_in_ready && k < 50) begin step(); k++; end
        w_lhs = a; w_rhs = b; w_in_signed = s; w_in_valid = 1'b1;
        q16.push_back(expv);
        step();
        w_in_valid = 1'b0;
        w_lhs = 16'($urandom); w_rhs = 16'($urandom);
        k = 0;
        while (!w_out_valid && k < 100) begin step(); k++; end
        n_checks++;
        if (k != 16) begin
            n_fail++;
            $display("FAIL %s latency got %0d want 16", name, k);
        end
        want = q16.pop_front();
        n_checks++;
        if (w_out_data !== want) begin
            n_fail++;
            $display("FAIL %s data got %h want %h", name, w_out_data, want);
        end
        step();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; in_signed = 1'b0; lhs = '0; rhs = '0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_in_signed = 1'b0; w_lhs = '0; w_rhs = '0; w_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 16'h0) begin
            n_fail++;
            $display("FAIL reset8 ready/valid/data got %b/%b/%h want 1/0/0000", in_ready, out_valid, out_data);
        end
        n_checks++;
        if (w_in_ready !== 1'b1 || w_out_valid !== 1'b0 || w_out_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset16 ready/valid/data got %b/%b/%h want 1/0/0", w_in_ready, w_out_valid, w_out_data);
        end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned;
        op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "u_ff_ff");
        op8(8'h12, 8'h34, 1'b0, 16'h03A8, "u_12_34");
        op8(8'h00, 8'hFF, 1'b0, 16'h0000, "u_00_ff");
    endtask

    task automatic test_signed;
        op8(8'h80, 8'h80, 1'b1, 16'h4000, "s_80_80");
        op8(8'hFF, 8'h03, 1'b1, 16'hFFFD, "s_ff_03");
        op8(8'h7F, 8'h80, 1'b1, 16'hC080, "s_7f_80");
        op8(8'h00, 8'h80, 1'b1, 16'h0000, "s_00_80");
    endtask

    task automatic test_backpressure;
        int k;
        logic [15:0] held;
        out_ready = 1'b0;
        lhs = 8'h5A; rhs = 8'hC3; in_signed = 1'b0; in_valid = 1'b1;
        q8.push_back(16'h448E);
        step();
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 50) begin step(); k++; end
        pop_check8("bp_result");
        held = 16'h448E;
        for (int c = 0; c < 10; c++) begin
            in_valid = (c % 2) == 0;
            lhs = 8'($urandom); rhs = 8'($urandom);
            step();
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d valid/data/ready got %b/%h/%b want 1/%h/0",
                         c, out_valid, out_data, in_ready, held);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== held) begin
            n_fail++;
            $display("FAIL bp_release valid/ready/data got %b/%b/%h want 0/1/%h", out_valid, in_ready, out_data, held);
        end
        repeat (6) step();
        n_checks++;
        if (out_valid !== 1'b0 || q8.size() != 0) begin
            n_fail++;
            $display("FAIL bp_no_extra valid got %b want 0, pending %0d want 0", out_valid, q8.size());
        end
    endtask

    task automatic test_reset_mid_op;
        out_ready = 1'b1;
        lhs = 8'hAB; rhs = 8'hCD; in_signed = 1'b0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid valid/data/ready got %b/%h/%b want 0/0000/1", out_valid, out_data, in_ready);
        end
        #2 rst_n = 1'b1;
        step();
        op8(8'h12, 8'h34, 1'b0, 16'h03A8, "reset_follow");
    endtask

    task automatic test_back_to_back;
        localparam int NOPS = 2000;
        logic [7:0] cl[8] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 8'h80, 8'hFF, 8'h01, 8'h81};
        logic [7:0] cr[8] = '{8'h80, 8'hFF, 8'h80, 8'h80, 8'h01, 8'h7F, 8'hFF, 8'h81};
        int accepts, last_acc, cyc, k;
        bit acc;
        accepts = 0; last_acc = -1; cyc = 0;
        out_ready = 1'b1;
        lhs = cl[0]; rhs = cr[0]; in_signed = 1'b0; in_valid = 1'b1;
        while (accepts < NOPS && cyc < NOPS * 6 + 100) begin
            acc = in_valid && in_ready;
            step();
            cyc++;
            if (acc) begin
                q8.push_back(16'(gold(64'(lhs), 64'(rhs), 8, in_signed)));
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != 6) begin
                        n_fail++;
                        $display("FAIL b2b_spacing op %0d got %0d want 6", accepts, cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepts++;
                if (accepts < 8) begin
                    lhs = cl[accepts]; rhs = cr[accepts]; in_signed = accepts[0];
                end else begin
                    lhs = 8'($urandom); rhs = 8'($urandom); in_signed = 1'($urandom);
                end
                if (accepts >= NOPS) in_valid = 1'b0;
            end
            if (out_valid) pop_check8("b2b_data");
        end
        k = 0;
        while (q8.size() > 0 && k < 50) begin
            step();
            if (out_valid) pop_check8("b2b_drain");
            k++;
        end
        n_checks++;
        if (accepts != NOPS || q8.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_count accepted %0d want %0d, pending %0d want 0", accepts, NOPS, q8.size());
        end
    endtask

    task automatic test_wide;
        op16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "w_u_ffff");
        op16(16'h8000, 16'hFFFF, 1'b1, 32'h00008000, "w_s_8000_ffff");
        op16(16'h1234, 16'hABCD, 1'b1, 32'(gold(64'h1234, 64'hABCD, 16, 1'b1)), "w_s_mixed");
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
